// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter that hands a shared 8-bit LED bank to one of four requesters,
// refreshing the owner's pattern on a divided time-base tick and forcing hand-over after HOLD_TICKS.
module led_bank_arbiter #(
    parameter int TICK_DIV   = 250,
    parameter int HOLD_TICKS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [31:0] pattern,
    input  logic [3:0]  done,
    output logic [3:0]  grant,
    output logic [7:0]  leds,
    output logic        tick,
    output logic        busy
);

    localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);
    localparam logic [7:0]  HOLD_MAX = 8'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tick_q;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  grant_q, grant_d;
    logic [7:0]  leds_q, leds_d;
    logic [1:0]  win, cand;
    logic        found;

    // Strobe lags the wrap by one edge, so the first tick lands TICK_DIV cycles after reset.
    assign cnt_d = (cnt_q == TICK_MAX) ? 16'd0 : cnt_q + 16'd1;

    always_comb begin
        win   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        leds_d  = leds_q;
        case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                if (|req) begin
                    state_d = GRANT;
                    owner_d = win;
                    grant_d = 4'b0001 << win;
                    leds_d  = pattern[{win, 3'b000} +: 8];
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                if (tick_q) begin
                    leds_d = pattern[{owner_q, 3'b000} +: 8];
                    if (hold_q != HOLD_MAX) hold_d = hold_q + 8'd1;
                end
                // Timeout only forces hand-over when someone else is actually waiting.
                if (done[owner_q] || !req[owner_q] ||
                    (tick_q && hold_q == HOLD_MAX && |(req & ~grant_q))) begin
                    state_d = RELEASE;
                    grant_d = 4'b0000;
                end
            end
            RELEASE: begin
                ptr_d   = owner_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            tick_q  <= 1'b0;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            hold_q  <= 8'd0;
            grant_q <= 4'b0000;
            leds_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= (cnt_q == TICK_MAX);
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            leds_q  <= leds_d;
        end
    end

    assign grant = grant_q;
    assign leds  = leds_q;
    assign tick  = tick_q;
    assign busy  = (state_q != IDLE);

endmodule
